signed_frame_mean_accumulator: RTL and testbench
================================================

# signed_frame_mean_accumulator

Downstream consumer of the signed pipelined fixed-point adder's 9-bit Q5.4 sum. The block accumulates frames of FRAME_LEN sums and divides each frame total by FRAME_LEN with an arithmetic shift. The quotient is saturated back to 8-bit Q4.4, and one mean per frame is handed to the next stage over a valid/ready handshake.

## Interface
Parameters:
- FRAME_LEN, 4: samples per frame; power of two, 2..256.
- SHIFT, $clog2(FRAME_LEN): derived; divide-by-FRAME_LEN shift amount.
- ACC_W, 9+SHIFT: derived; accumulator width. It cannot overflow.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous frame abort.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  9  signed Q5.4 sample (adder Sum).
- out_valid  out  1  out_data holds a frame mean.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  8  signed Q4.4 saturated frame mean.
- out_sat  out  1  out_data was clipped.

## Operation
- Two states, ACCUM and HOLD. Reset state is ACCUM.
- ACCUM:
  - in_ready=1.
  - On in_valid&&in_ready: acc += sext(in_data) and cnt++.
  - On the sample with cnt==FRAME_LEN-1: register the result into out_data/out_sat, zero acc and cnt, go to HOLD.
- HOLD:
  - in_ready=0 and out_valid=1.
  - out_data/out_sat stay stable until out_ready.
  - On out_valid&&out_ready: go to ACCUM.
- Result computation:
  - total = acc + in_data, taken from the final sample, computed at ACC_W bits.
  - q = total >>> SHIFT, arithmetic.
  - Saturate q to [-128, 127]. out_sat=1 when clipped.
- clear: in any state, next edge returns to ACCUM with acc=0, cnt=0, out_valid=0. A frame pending in HOLD is discarded.
- clear priority:
  - clear beats an in_valid handshake in the same cycle; that sample is dropped.
  - clear beats out_ready; no transfer is counted.
- in_data is ignored when in_valid=0, and when in HOLD.
- cnt wraps only through the frame-complete path. No partial frame is ever emitted.

## Timing
- Reset values: out_valid=0, out_data=0, out_sat=0, in_ready=1, acc=0, cnt=0, state=ACCUM.
- Assertion of rst_n mid-frame discards the partial accumulation immediately (asynchronous).
- Latency: the last sample is accepted at edge k, and out_valid is high from edge k.
- Throughput:
  - Back-to-back with out_ready=1: FRAME_LEN+1 cycles per frame.
  - In-flight HOLD cycle: in_ready=0.
- out_valid never drops without a handshake, except on clear or rst_n.
- All outputs are registered, except in_ready, which is decoded from the state register.

## Configuration
- ACC_ROUND_EN defined: total + 2^(SHIFT-1) before the shift. Rounds half toward +inf; applied before saturation.
- ACC_ROUND_EN undefined: plain arithmetic shift (floor). No rounding adder is instantiated.

## Structure
- Package fxp_pkg holds:
  - IN_W=9, OUT_W=8, FRAC_W=4.
  - OUT_MAX=127, OUT_MIN=-128.
  - The state enum {ACCUM, HOLD}.
- Sub-module fxp_round_sat is combinational.
  - Parameters: ACC_W and SHIFT.
  - Performs shift, optional rounding and saturation.
  - Outputs the 8-bit value and the sat flag.
- The top module holds the FSM, counter, accumulator and output registers.

## Test plan
All scenarios use FRAME_LEN=4.
- Samples 25, 40, -15, 126 (in raw units) with out_ready=1: out_data=44, out_sat=0. out_valid is high for exactly one cycle, one cycle after the 4th accept.
- Samples 1, 1, 0, 0: out_data=1 with ACC_ROUND_EN; out_data=0 without. Samples -1, -1, 0, 0: out_data=0 with ACC_ROUND_EN; out_data=-1 without.
- 4×255 gives out_data=127 with out_sat=1. 4×-256 gives out_data=-128 with out_sat=1.
- Hold out_ready=0 for 5 cycles in HOLD: out_data stays stable and in_ready=0. With in_valid held high, no samples are accepted. The next frame starts after the handshake.
- Assert clear after 2 samples, together with in_valid: that sample is dropped and cnt=0. The next 4 samples form a fresh frame with the correct mean.
- Drop rst_n mid-frame between clock edges: outputs return to reset values immediately. The first frame after release excludes the pre-reset samples.

Source files
------------

// File: rtl/signed_frame_mean_accumulator_pkg.sv
// Shared fixed-point constants and FSM state type for the frame mean path.
// Build option: ACC_ROUND_EN selects round-half-up instead of floor.
package fxp_pkg;

    localparam int IN_W    = 9;
    localparam int OUT_W   = 8;
    localparam int FRAC_W  = 4;
    localparam int OUT_MAX = 127;
    localparam int OUT_MIN = -128;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/signed_frame_mean_accumulator_if.sv
// Sample-in / mean-out valid-ready bundle for the frame mean accumulator.
// Build option: ACC_ROUND_EN (no effect on this interface).
interface signed_frame_mean_accumulator_if;
    import fxp_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

endinterface

// File: rtl/signed_frame_mean_accumulator_round_sat.sv
// Divide a frame total by 2^SHIFT and clip to signed Q4.4.
// Build option: ACC_ROUND_EN adds half an LSB before the shift.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int ACC_W = 11,
    parameter int SHIFT = 2
) (
    input  logic signed [ACC_W-1:0] total,
    output logic        [OUT_W-1:0] data,
    output logic                    sat
);

    localparam logic signed [ACC_W:0] MAX_W = (ACC_W+1)'(OUT_MAX);
    localparam logic signed [ACC_W:0] MIN_W = (ACC_W+1)'(OUT_MIN);

    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] q;

`ifdef ACC_ROUND_EN
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1 << (SHIFT - 1));
    // One extra bit keeps the rounding add from wrapping.
    assign biased = {total[ACC_W-1], total} + HALF;
`else
    assign biased = {total[ACC_W-1], total};
`endif

    assign q = biased >>> SHIFT;

    always_comb begin
        data = q[OUT_W-1:0];
        sat  = 1'b0;
        if (q > MAX_W) begin
            data = OUT_W'(OUT_MAX);
            sat  = 1'b1;
        end else if (q < MIN_W) begin
            data = OUT_W'(OUT_MIN);
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/signed_frame_mean_accumulator.sv
// Accumulates FRAME_LEN Q5.4 samples and emits one saturated Q4.4 mean per frame.
// Build option: ACC_ROUND_EN rounds the mean half toward +inf.
module signed_frame_mean_accumulator
    import fxp_pkg::*;
#(
    parameter int FRAME_LEN = 4,
    parameter int SHIFT     = $clog2(FRAME_LEN),
    parameter int ACC_W     = IN_W + SHIFT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    signed_frame_mean_accumulator_if.slave bus
);

    state_e state_q, state_d;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [SHIFT-1:0] cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic        [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;

    logic signed [ACC_W-1:0] total;
    logic        [OUT_W-1:0] rs_data;
    logic                    rs_sat;
    logic                    last;

    assign total = acc_q + {{SHIFT{bus.in_data[IN_W-1]}}, bus.in_data};
    assign last  = (cnt_q == SHIFT'(FRAME_LEN - 1));

    fxp_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .total (total),
        .data  (rs_data),
        .sat   (rs_sat)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (clear) begin
            state_d     = ACCUM;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (bus.in_valid) begin
                        if (last) begin
                            state_d     = HOLD;
                            acc_d       = '0;
                            cnt_d       = '0;
                            out_valid_d = 1'b1;
                            out_data_d  = rs_data;
                            out_sat_d   = rs_sat;
                        end else begin
                            acc_d = total;
                            cnt_d = cnt_q + SHIFT'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d     = ACCUM;
                        out_valid_d = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_signed_frame_mean_accumulator.sv
// Directed bench for the frame mean accumulator, FRAME_LEN=4.
// Build option: ACC_ROUND_EN changes the expected rounding results.
module tb_signed_frame_mean_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    signed_frame_mean_accumulator_if bus();

    signed_frame_mean_accumulator #(.FRAME_LEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic frame(input string tag, input logic [8:0] a, input logic [8:0] b,
                         input logic [8:0] c, input logic [8:0] d,
                         input logic [7:0] exp_data, input logic exp_sat);
        send(a);
        send(b);
        send(c);
        chk({tag, "_pre_valid"}, 8'(bus.out_valid), 8'd0);
        send(d);
        chk({tag, "_valid"}, 8'(bus.out_valid), 8'd1);
        chk({tag, "_data"}, bus.out_data, exp_data);
        chk({tag, "_sat"}, 8'(bus.out_sat), 8'(exp_sat));
        chk({tag, "_in_ready"}, 8'(bus.in_ready), 8'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #3;
        chk("rst_valid", 8'(bus.out_valid), 8'd0);
        chk("rst_data", bus.out_data, 8'd0);
        chk("rst_sat", 8'(bus.out_sat), 8'd0);
        chk("rst_in_ready", 8'(bus.in_ready), 8'd1);
        #10 rst_n = 1'b1;
        tick();

        frame("mean44", 9'(25), 9'(40), 9'(-15), 9'(126), 8'd44, 1'b0);
        tick();
        chk("mean44_one_cycle", 8'(bus.out_valid), 8'd0);
        chk("mean44_ready_back", 8'(bus.in_ready), 8'd1);

`ifdef ACC_ROUND_EN
        frame("rnd_pos", 9'(1), 9'(1), 9'(0), 9'(0), 8'd1, 1'b0);
        tick();
        frame("rnd_neg", 9'(-1), 9'(-1), 9'(0), 9'(0), 8'd0, 1'b0);
`else
        frame("rnd_pos", 9'(1), 9'(1), 9'(0), 9'(0), 8'd0, 1'b0);
        tick();
        frame("rnd_neg", 9'(-1), 9'(-1), 9'(0), 9'(0), 8'(-1), 1'b0);
`endif
        tick();

        frame("sat_hi", 9'(255), 9'(255), 9'(255), 9'(255), 8'd127, 1'b1);
        tick();
        frame("sat_lo", 9'(-256), 9'(-256), 9'(-256), 9'(-256), 8'(-128), 1'b1);
        tick();

        bus.out_ready = 1'b0;
        frame("hold", 9'(10), 9'(10), 9'(10), 9'(10), 8'd10, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 9'(100);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 8'(bus.out_valid), 8'd1);
            chk("hold_data", bus.out_data, 8'd10);
            chk("hold_in_ready", 8'(bus.in_ready), 8'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("hold_release", 8'(bus.out_valid), 8'd0);
        frame("after_hold", 9'(4), 9'(4), 9'(4), 9'(4), 8'd4, 1'b0);
        tick();

        send(9'(50));
        send(9'(50));
        bus.in_valid = 1'b1;
        bus.in_data  = 9'(50);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        chk("clear_valid", 8'(bus.out_valid), 8'd0);
        frame("after_clear", 9'(8), 9'(8), 9'(8), 9'(8), 8'd8, 1'b0);
        tick();

        bus.out_ready = 1'b0;
        frame("pend", 9'(20), 9'(20), 9'(20), 9'(20), 8'd20, 1'b0);
        clear = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_hold_valid", 8'(bus.out_valid), 8'd0);
        chk("clear_hold_ready", 8'(bus.in_ready), 8'd1);

        send(9'(100));
        send(9'(100));
        #2 rst_n = 1'b0;
        #1;
        chk("async_data", bus.out_data, 8'd0);
        chk("async_valid", 8'(bus.out_valid), 8'd0);
        chk("async_in_ready", 8'(bus.in_ready), 8'd1);
        #2 rst_n = 1'b1;
        tick();
        frame("after_rst", 9'(12), 9'(12), 9'(12), 9'(12), 8'd12, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
